shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle shift/rotate execution unit for the 8088 core's group-2 instructions (ROL, ROR, RCL, RCR, SHL/SAL, SHR, SAR) with a count of 1 or CL. It accepts one operation through a start/busy/done handshake and performs one single-bit step per clock, chaining carry between steps. It returns the final result plus the flag set and a flag-write enable to the execution unit. The CL count is not masked: the full 8-bit count is honoured, as on the 8088.

## Interface
- No parameters.
- CLK  in  1  core clock, all state on rising edge
- RESETn  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- Operation  in  3  000 ROL, 001 ROR, 010 RCL, 011 RCR, 100 SHL, 101 SHR, 110 alias of SHL, 111 SAR
- byteWord  in  1  0 = 8-bit operand, 1 = 16-bit operand
- A  in  16  operand
- count  in  8  iteration count (1 or CL)
- carryIn  in  1  current CF
- busy  out  1  high from the cycle after start is accepted through the done cycle
- done  out  1  one-cycle pulse; S and flags are valid in this cycle
- S  out  16  result register
- flag_we  out  1  valid with done; 0 when count == 0 (flags must be left unchanged)
- F_Carry, F_Overflow, F_Neg, F_Zero, F_Aux, F_Parity  out  1 each  registered flags

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: latch Operation, byteWord, count into cnt, S<=A, C<=carryIn. Go to DONE if count==0, else RUN.
- RUN, each edge: one step on S using C, with width W = 8 or 16 and msb = W-1.
  - ROL: {S[msb-1:0], S[msb]}. ROR: {S[0], S[msb:1]}.
  - RCL: {S[msb-1:0], C}. RCR: {C, S[msb:1]}.
  - SHL: {S[msb-1:0], 0}. SHR: {0, S[msb:1]}. SAR: {S[msb], S[msb:1]}.
  - Step carry = pre-step S[msb] for left ops (ROL, RCL, SHL). Step carry = pre-step S[0] for right ops.
  - Step overflow:
    - ROL/RCL: new S[msb] ^ new carry.
    - ROR/RCR: new S[msb] ^ new S[msb-1].
    - SHL: pre-step S[msb] ^ pre-step S[msb-1].
    - SHR: pre-step S[msb].
    - SAR: 0.
  - C <= step carry. cnt <= cnt-1. Go to DONE when cnt==1.
- Byte mode: S[15:8] holds the latched A[15:8] unchanged throughout.
- Flag outputs are loaded on the last step:
  - F_Carry = C. F_Overflow = last step overflow.
  - F_Neg = S[msb]. F_Zero = (S[W-1:0]==0). F_Aux = S[4].
  - F_Parity = even parity of S[7:0] (1 when the number of set bits is even).
  - For count==0, all flag outputs are 0.
- DONE: done=1. flag_we=(latched count!=0). Go to IDLE next edge.
- start is ignored while in RUN or DONE. A new start is accepted no earlier than the IDLE cycle after done.
- Inputs are latched, so input changes after acceptance have no effect.

## Timing
- Reset (asynchronous, any state including mid-RUN): state=IDLE, cnt=0, C=0, S=0, busy=0, done=0, flag_we=0, all F_* = 0. The operation in progress is discarded with no done.
- start sampled at edge k:
  - count N≥1: done high in the cycle after edge k+N.
  - count 0: done high in the cycle after edge k.
- Latency is max(N,1) cycles; count 255 takes 255 steps.
- busy falls together with done, at the edge that returns to IDLE.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- S changes every RUN cycle. S and the flags are stable from done until the next accepted start.

## Test plan
- SHL byte, A=0x0081, count=1, carryIn=0 -> done after 1 cycle, S=0x0002, C=1, O=1, Z=0, P=0, flag_we=1.
- ROR word, A=0x0001, count=4 -> done after 4 cycles, S=0x1000, C=0, O=0, N=0.
- RCL byte, A=0x0080, carryIn=0, count=9 -> S=0x0080, C=0, O=1, N=1; S[15:8] unchanged.
- SAR word, A=0x8000, count=255 -> done after 255 cycles, S=0xFFFF, C=1, O=0, N=1, P=1. A start pulse mid-run is ignored.
- count=0, A=0x1234, any op -> done after 1 cycle, S=0x1234, flag_we=0.
- RESETn asserted mid-RUN (ROL word, count=10, after 3 steps) -> immediately IDLE, S=0, busy=0, no done pulse. A following start (count=1) completes normally.

Source files
------------

// File: rtl/shift_sequencer.sv
// ----------------------------------------------------------------------------
// shift_sequencer : multi-cycle group-2 shift/rotate unit, one bit step per clock
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module shift_sequencer (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        start,
  input  logic [2:0]  Operation,
  input  logic        byteWord,
  input  logic [15:0] A,
  input  logic [7:0]  count,
  input  logic        carryIn,
  output logic        busy,
  output logic        done,
  output logic [15:0] S,
  output logic        flag_we,
  output logic        F_Carry,
  output logic        F_Overflow,
  output logic        F_Neg,
  output logic        F_Zero,
  output logic        F_Aux,
  output logic        F_Parity
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [2:0] c_ROL = 3'b000;
  localparam logic [2:0] c_ROR = 3'b001;
  localparam logic [2:0] c_RCL = 3'b010;
  localparam logic [2:0] c_RCR = 3'b011;
  localparam logic [2:0] c_SHR = 3'b101;
  localparam logic [2:0] c_SAR = 3'b111;

  logic [1:0]  state_q, state_d;
  logic [2:0]  op_q;
  logic        bw_q;
  logic [7:0]  cnt_q;
  logic        nz_q;
  logic [15:0] s_q;
  logic        c_q;
  logic [5:0]  flags_q;  // {C, O, N, Z, Aux, P}

  logic        w_left;
  logic        w_pre_msb, w_pre_msbm1;
  logic        w_lin, w_rin;
  logic [15:0] w_step_s;
  logic        w_step_c;
  logic        w_new_msb, w_new_msbm1;
  logic        w_step_o;
  logic        w_step_z;

  // Even opcodes (including the 110 SHL alias) shift toward the msb.
  always_comb begin
    w_left      = ~op_q[0];
    w_pre_msb   = bw_q ? s_q[15] : s_q[7];
    w_pre_msbm1 = bw_q ? s_q[14] : s_q[6];
    w_lin       = 1'b0;
    w_rin       = 1'b0;
    case (op_q)
      c_ROL:   w_lin = w_pre_msb;
      c_RCL:   w_lin = c_q;
      c_ROR:   w_rin = s_q[0];
      c_RCR:   w_rin = c_q;
      c_SAR:   w_rin = w_pre_msb;
      default: begin
        w_lin = 1'b0;
        w_rin = 1'b0;
      end
    endcase

    if (bw_q)
      w_step_s = w_left ? {s_q[14:0], w_lin} : {w_rin, s_q[15:1]};
    else
      w_step_s = w_left ? {s_q[15:8], s_q[6:0], w_lin} : {s_q[15:8], w_rin, s_q[7:1]};

    w_step_c    = w_left ? w_pre_msb : s_q[0];
    w_new_msb   = bw_q ? w_step_s[15] : w_step_s[7];
    w_new_msbm1 = bw_q ? w_step_s[14] : w_step_s[6];
    w_step_z    = bw_q ? (w_step_s == 16'h0000) : (w_step_s[7:0] == 8'h00);

    case (op_q)
      c_ROL, c_RCL: w_step_o = w_new_msb ^ w_step_c;
      c_ROR, c_RCR: w_step_o = w_new_msb ^ w_new_msbm1;
      c_SHR:        w_step_o = w_pre_msb;
      c_SAR:        w_step_o = 1'b0;
      default:      w_step_o = w_pre_msb ^ w_pre_msbm1;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_q <= c_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (start) state_d = (count == 8'd0) ? c_DONE : c_RUN;
      c_RUN:   if (cnt_q == 8'd1) state_d = c_DONE;
      c_DONE:  state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != c_IDLE);
    done    = (state_q == c_DONE);
    flag_we = (state_q == c_DONE) & nz_q;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      op_q    <= 3'b000;
      bw_q    <= 1'b0;
      cnt_q   <= 8'd0;
      nz_q    <= 1'b0;
      s_q     <= 16'h0000;
      c_q     <= 1'b0;
      flags_q <= 6'b000000;
    end else begin
      case (state_q)
        c_IDLE: begin
          if (start) begin
            op_q    <= Operation;
            bw_q    <= byteWord;
            cnt_q   <= count;
            nz_q    <= (count != 8'd0);
            s_q     <= A;
            c_q     <= carryIn;
            flags_q <= 6'b000000;
          end
        end
        c_RUN: begin
          s_q   <= w_step_s;
          c_q   <= w_step_c;
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1)
            flags_q <= {w_step_c, w_step_o, w_new_msb, w_step_z, w_step_s[4], ~^w_step_s[7:0]};
        end
        default: ;
      endcase
    end
  end

  assign S          = s_q;
  assign F_Carry    = flags_q[5];
  assign F_Overflow = flags_q[4];
  assign F_Neg      = flags_q[3];
  assign F_Zero     = flags_q[2];
  assign F_Aux      = flags_q[1];
  assign F_Parity   = flags_q[0];

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ----------------------------------------------------------------------------
// tb_shift_sequencer : directed vector bench for shift_sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_shift_sequencer;

  logic        CLK;
  logic        RESETn;
  logic        start;
  logic [2:0]  Operation;
  logic        byteWord;
  logic [15:0] A;
  logic [7:0]  count;
  logic        carryIn;
  logic        busy;
  logic        done;
  logic [15:0] S;
  logic        flag_we;
  logic        F_Carry, F_Overflow, F_Neg, F_Zero, F_Aux, F_Parity;

  int n_vec = 0;
  int n_err = 0;

  shift_sequencer dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .start      (start),
    .Operation  (Operation),
    .byteWord   (byteWord),
    .A          (A),
    .count      (count),
    .carryIn    (carryIn),
    .busy       (busy),
    .done       (done),
    .S          (S),
    .flag_we    (flag_we),
    .F_Carry    (F_Carry),
    .F_Overflow (F_Overflow),
    .F_Neg      (F_Neg),
    .F_Zero     (F_Zero),
    .F_Aux      (F_Aux),
    .F_Parity   (F_Parity)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  op;
    logic        bw;
    logic [15:0] a;
    logic [7:0]  cnt;
    logic        cin;
    logic [15:0] exp_s;
    logic [5:0]  exp_f;   // {C, O, N, Z, Aux, P}
    logic        exp_we;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [5:0] flags();
    return {F_Carry, F_Overflow, F_Neg, F_Zero, F_Aux, F_Parity};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [2:0] op, input logic bw, input logic [15:0] a,
                        input logic [7:0] cnt, input logic cin);
    @(negedge CLK);
    Operation = op; byteWord = bw; A = a; count = cnt; carryIn = cin;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    Operation = ~op; byteWord = ~bw; A = ~a; count = 8'd7; carryIn = ~cin;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    @(negedge CLK);
    while (!done && edges < 400) begin
      @(negedge CLK);
      edges++;
    end
  endtask

  initial begin
    int edges;
    int done_seen;

    vecs[0]  = '{3'b100, 1'b0, 16'h0081, 8'd1,  1'b0, 16'h0002, 6'b110000, 1'b1};
    vecs[1]  = '{3'b001, 1'b1, 16'h0001, 8'd4,  1'b0, 16'h1000, 6'b000001, 1'b1};
    vecs[2]  = '{3'b010, 1'b0, 16'hAB80, 8'd9,  1'b0, 16'hAB80, 6'b011000, 1'b1};
    vecs[3]  = '{3'b000, 1'b1, 16'h1234, 8'd0,  1'b0, 16'h1234, 6'b000000, 1'b0};
    vecs[4]  = '{3'b101, 1'b0, 16'h0001, 8'd1,  1'b0, 16'h0000, 6'b100101, 1'b1};
    vecs[5]  = '{3'b000, 1'b1, 16'h8001, 8'd1,  1'b0, 16'h0003, 6'b110001, 1'b1};
    vecs[6]  = '{3'b011, 1'b1, 16'h0002, 8'd2,  1'b1, 16'h4000, 6'b110001, 1'b1};
    vecs[7]  = '{3'b111, 1'b0, 16'h5590, 8'd3,  1'b0, 16'h55F2, 6'b001010, 1'b1};
    vecs[8]  = '{3'b110, 1'b1, 16'h4000, 8'd1,  1'b0, 16'h8000, 6'b011001, 1'b1};
    vecs[9]  = '{3'b101, 1'b1, 16'h8000, 8'd16, 1'b0, 16'h0000, 6'b100101, 1'b1};
    vecs[10] = '{3'b001, 1'b0, 16'h1201, 8'd1,  1'b0, 16'h1280, 6'b111000, 1'b1};
    vecs[11] = '{3'b010, 1'b1, 16'h0000, 8'd1,  1'b1, 16'h0001, 6'b000000, 1'b1};
    vecs[12] = '{3'b000, 1'b0, 16'hFF10, 8'd4,  1'b0, 16'hFF01, 6'b110000, 1'b1};

    RESETn = 1'b0; start = 1'b0; Operation = 3'b000; byteWord = 1'b0;
    A = 16'h0000; count = 8'd0; carryIn = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset S", S, 16'h0000);
    check("reset busy/done/we", {busy, done, flag_we}, 3'b000);
    check("reset flags", flags(), 6'b000000);
    RESETn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      launch(vecs[i].op, vecs[i].bw, vecs[i].a, vecs[i].cnt, vecs[i].cin);
      wait_done(edges);
      check($sformatf("v%0d latency", i), edges, {24'd0, vecs[i].cnt});
      check($sformatf("v%0d S", i), S, vecs[i].exp_s);
      check($sformatf("v%0d flags", i), flags(), vecs[i].exp_f);
      check($sformatf("v%0d flag_we", i), flag_we, vecs[i].exp_we);
      check($sformatf("v%0d busy@done", i), busy, 1'b1);
      @(negedge CLK);
      check($sformatf("v%0d idle busy/done", i), {busy, done, flag_we}, 3'b000);
      check($sformatf("v%0d S hold", i), S, vecs[i].exp_s);
    end

    // SAR word x255 with an ignored start pulse in the middle of the run.
    launch(3'b111, 1'b1, 16'h8000, 8'd255, 1'b0);
    Operation = 3'b000; byteWord = 1'b0; A = 16'h0000; count = 8'd1;
    edges = 0;
    @(negedge CLK);
    while (!done && edges < 400) begin
      @(negedge CLK);
      edges++;
      start = (edges == 100);
    end
    start = 1'b0;
    check("sar255 latency", edges, 255);
    check("sar255 S", S, 16'hFFFF);
    check("sar255 flags", flags(), 6'b101011);
    check("sar255 flag_we", flag_we, 1'b1);
    @(negedge CLK);
    check("sar255 idle", {busy, done}, 2'b00);

    // Asynchronous reset in the middle of a run discards it.
    launch(3'b000, 1'b1, 16'h1234, 8'd10, 1'b0);
    repeat (3) @(posedge CLK);
    #2;
    RESETn = 1'b0;
    #1;
    check("midreset S", S, 16'h0000);
    check("midreset busy/done/we", {busy, done, flag_we}, 3'b000);
    check("midreset flags", flags(), 6'b000000);
    @(negedge CLK);
    RESETn = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(negedge CLK);
      if (done) done_seen++;
    end
    check("midreset no done", done_seen, 0);
    check("midreset idle busy", busy, 1'b0);

    launch(3'b100, 1'b0, 16'h0040, 8'd1, 1'b0);
    wait_done(edges);
    check("post-reset latency", edges, 1);
    check("post-reset S", S, 16'h0080);
    check("post-reset flags", flags(), 6'b011000);
    check("post-reset flag_we", flag_we, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
